// File: rtl/core_pkg.sv
// Shared RV32I core encodings: opcodes, datapath selects and
// the multicycle control state set.
package core_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_BRANCH = 7'b1100011,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  typedef enum logic {
    ADD_OP = 1'b0,
    ALU_OP = 1'b1
  } aluctrl_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'd0,
    SRCA_OLDPC = 2'd1,
    SRCA_RS1   = 2'd2,
    SRCA_ZERO  = 2'd3
  } srca_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'd0,
    SRCB_IMM  = 2'd1,
    SRCB_FOUR = 2'd2
  } srcb_e;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'd0,
    RES_DATA      = 2'd1,
    RES_ALURESULT = 2'd2
  } result_e;

  typedef enum logic {
    ADR_PC     = 1'b0,
    ADR_RESULT = 1'b1
  } adr_e;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LINK,
    S_LUI,
    S_AUIPC,
    S_TRAP
  } state_e;

endpackage

// File: rtl/control_fsm_if.sv
// Memory request handshake between the control FSM and memory.
interface control_fsm_if;
  logic memRead;
  logic memWrite;
  logic memReady;

  modport master (
    output memRead,
    output memWrite,
    input  memReady
  );

  modport slave (
    input  memRead,
    input  memWrite,
    output memReady
  );
endinterface

// File: rtl/branch_cond.sv
// Branch condition decode: func3 plus comparator flags to taken,
// with the two unassigned func3 codes flagged illegal.
module branch_cond (
  input  logic [2:0] i_func3,
  input  logic       i_eq,
  input  logic       i_lt,
  input  logic       i_ltu,
  output logic       o_taken,
  output logic       o_illegal
);

  always_comb begin
    o_taken   = 1'b0;
    o_illegal = 1'b0;
    unique case (i_func3)
      3'b000:  o_taken = i_eq;
      3'b001:  o_taken = ~i_eq;
      3'b100:  o_taken = i_lt;
      3'b101:  o_taken = ~i_lt;
      3'b110:  o_taken = i_ltu;
      3'b111:  o_taken = ~i_ltu;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle RV32I control: fetch/decode/execute/mem/writeback
// sequencing, datapath selects and memory handshake.
module control_fsm
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        opcode,
  input  logic [2:0]        func3,
  input  logic              eq,
  input  logic              lt,
  input  logic              ltu,
  control_fsm_if.master     mem,
  output logic              adrSrc,
  output logic              irWrite,
  output logic              pcWrite,
  output logic              regWrite,
  output logic [1:0]        aluSrcA,
  output logic [1:0]        aluSrcB,
  output logic [1:0]        resultSrc,
  output logic              aluCtrl,
  output logic              retire,
  output logic              trap
);

  state_e r_state;
  state_e w_next;
  logic   w_taken;
  logic   w_illegal;

  branch_cond u_branch_cond (
    .i_func3   (func3),
    .i_eq      (eq),
    .i_lt      (lt),
    .i_ltu     (ltu),
    .o_taken   (w_taken),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    mem.memRead  = 1'b0;
    mem.memWrite = 1'b0;
    adrSrc       = ADR_PC;
    irWrite      = 1'b0;
    pcWrite      = 1'b0;
    regWrite     = 1'b0;
    aluSrcA      = SRCA_PC;
    aluSrcB      = SRCB_RS2;
    resultSrc    = RES_ALUOUT;
    aluCtrl      = ADD_OP;
    retire       = 1'b0;
    trap         = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        mem.memRead = 1'b1;
        aluSrcB     = SRCB_FOUR;
        resultSrc   = RES_ALURESULT;
        irWrite     = mem.memReady;
        pcWrite     = mem.memReady;
        if (mem.memReady) w_next = S_DECODE;
      end
      S_DECODE: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
        unique case (opcode)
          OPC_LOAD,
          OPC_STORE:  w_next = S_MEMADR;
          OPC_OP:     w_next = S_EXECR;
          OPC_OP_IMM: w_next = S_EXECI;
          OPC_BRANCH: w_next = S_BRANCH;
          OPC_JAL:    w_next = S_JAL;
          OPC_JALR:   w_next = S_JALR;
          OPC_LUI:    w_next = S_LUI;
          OPC_AUIPC:  w_next = S_AUIPC;
          default:    w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
        w_next  = (opcode == OPC_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem.memRead = 1'b1;
        adrSrc      = ADR_RESULT;
        if (mem.memReady) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        resultSrc = RES_DATA;
        regWrite  = 1'b1;
        retire    = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem.memWrite = 1'b1;
        adrSrc       = ADR_RESULT;
        retire       = mem.memReady;
        if (mem.memReady) w_next = S_FETCH;
      end
      S_EXECR: begin
        aluSrcA = SRCA_RS1;
        aluCtrl = ALU_OP;
        w_next  = S_ALUWB;
      end
      S_EXECI: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
        aluCtrl = ALU_OP;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        regWrite = 1'b1;
        retire   = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        pcWrite = w_taken & ~w_illegal;
        retire  = ~w_illegal;
        w_next  = w_illegal ? S_TRAP : S_FETCH;
      end
      S_JAL: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_FOUR;
        pcWrite = 1'b1;
        w_next  = S_ALUWB;
      end
      S_JALR: begin
        aluSrcA   = SRCA_RS1;
        aluSrcB   = SRCB_IMM;
        resultSrc = RES_ALURESULT;
        pcWrite   = 1'b1;
        w_next    = S_LINK;
      end
      S_LINK: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_FOUR;
        w_next  = S_ALUWB;
      end
      S_LUI: begin
        aluSrcA = SRCA_ZERO;
        aluSrcB = SRCB_IMM;
        w_next  = S_ALUWB;
      end
      S_AUIPC: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
        w_next  = S_ALUWB;
      end
      S_TRAP: begin
        trap   = 1'b1;
        w_next = S_TRAP;
      end
      default: w_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Directed vector bench for control_fsm: per-cycle table plus
// reset / trap / illegal-branch corner sequences.
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       eq, lt, ltu;
  logic       adrSrc, irWrite, pcWrite, regWrite;
  logic [1:0] aluSrcA, aluSrcB, resultSrc;
  logic       aluCtrl, retire, trap;

  control_fsm_if mem ();

  control_fsm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .func3     (func3),
    .eq        (eq),
    .lt        (lt),
    .ltu       (ltu),
    .mem       (mem),
    .adrSrc    (adrSrc),
    .irWrite   (irWrite),
    .pcWrite   (pcWrite),
    .regWrite  (regWrite),
    .aluSrcA   (aluSrcA),
    .aluSrcB   (aluSrcB),
    .resultSrc (resultSrc),
    .aluCtrl   (aluCtrl),
    .retire    (retire),
    .trap      (trap)
  );

  always #5 clk = ~clk;

  // {memRead,memWrite,adrSrc,irWrite,pcWrite,regWrite,A,B,res,ctl,ret,trap}
  logic [14:0] act;
  assign act = {mem.memRead, mem.memWrite, adrSrc, irWrite,
                pcWrite, regWrite, aluSrcA, aluSrcB, resultSrc,
                aluCtrl, retire, trap};

  localparam logic [14:0] X_F1   = {6'b100110, 2'd0, 2'd2, 2'd2, 3'b000};
  localparam logic [14:0] X_F0   = {6'b100000, 2'd0, 2'd2, 2'd2, 3'b000};
  localparam logic [14:0] X_DEC  = {6'b000000, 2'd1, 2'd1, 2'd0, 3'b000};
  localparam logic [14:0] X_EXI  = {6'b000000, 2'd2, 2'd1, 2'd0, 3'b100};
  localparam logic [14:0] X_EXR  = {6'b000000, 2'd2, 2'd0, 2'd0, 3'b100};
  localparam logic [14:0] X_AWB  = {6'b000001, 2'd0, 2'd0, 2'd0, 3'b010};
  localparam logic [14:0] X_MADR = {6'b000000, 2'd2, 2'd1, 2'd0, 3'b000};
  localparam logic [14:0] X_MRD  = {6'b101000, 2'd0, 2'd0, 2'd0, 3'b000};
  localparam logic [14:0] X_MWB  = {6'b000001, 2'd0, 2'd0, 2'd1, 3'b010};
  localparam logic [14:0] X_MWR0 = {6'b011000, 2'd0, 2'd0, 2'd0, 3'b000};
  localparam logic [14:0] X_MWR1 = {6'b011000, 2'd0, 2'd0, 2'd0, 3'b010};
  localparam logic [14:0] X_BRT  = {6'b000010, 2'd0, 2'd0, 2'd0, 3'b010};
  localparam logic [14:0] X_BRN  = {6'b000000, 2'd0, 2'd0, 2'd0, 3'b010};
  localparam logic [14:0] X_BRI  = 15'd0;
  localparam logic [14:0] X_JAL  = {6'b000010, 2'd1, 2'd2, 2'd0, 3'b000};
  localparam logic [14:0] X_JALR = {6'b000010, 2'd2, 2'd1, 2'd2, 3'b000};
  localparam logic [14:0] X_LINK = {6'b000000, 2'd1, 2'd2, 2'd0, 3'b000};
  localparam logic [14:0] X_LUI  = {6'b000000, 2'd3, 2'd1, 2'd0, 3'b000};
  localparam logic [14:0] X_AUI  = {6'b000000, 2'd1, 2'd1, 2'd0, 3'b000};
  localparam logic [14:0] X_TRAP = {6'b000000, 2'd0, 2'd0, 2'd0, 3'b001};

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] JLR = 7'b1100111;
  localparam logic [6:0] LU  = 7'b0110111;
  localparam logic [6:0] AUI = 7'b0010111;
  localparam logic [6:0] SYS = 7'b1110011;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [2:0]  flg;
    logic        rdy;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;
  int   retires  = 0;

  task automatic add(input logic [6:0] op, input logic [2:0] f3,
                     input logic [2:0] flg, input logic rdy,
                     input logic [14:0] exp);
    vec_t v;
    v.op = op; v.f3 = f3; v.flg = flg; v.rdy = rdy; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b want=%b", nm, act, exp);
    end
  endtask

  task automatic step(input string nm, input logic [6:0] op,
                      input logic [2:0] f3, input logic [2:0] flg,
                      input logic rdy, input logic [14:0] exp);
    @(negedge clk);
    opcode = op;
    func3 = f3;
    {eq, lt, ltu} = flg;
    mem.memReady = rdy;
    #1;
    check(nm, exp);
    if (retire === 1'b1) retires++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem.memReady = 1'b0;
    #1;
    check("rst_fetch", X_F0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = OPI;
    func3 = 3'd0;
    {eq, lt, ltu} = 3'b000;
    mem.memReady = 1'b0;

    // flg = {eq, lt, ltu}
    add(OPI, 0, 0, 1, X_F1); add(OPI, 0, 0, 1, X_DEC);
    add(OPI, 0, 0, 1, X_EXI); add(OPI, 0, 0, 1, X_AWB);
    add(OPR, 0, 0, 1, X_F1); add(OPR, 0, 0, 1, X_DEC);
    add(OPR, 0, 0, 1, X_EXR); add(OPR, 0, 0, 1, X_AWB);
    add(LD, 2, 0, 1, X_F1); add(LD, 2, 0, 1, X_DEC);
    add(LD, 2, 0, 1, X_MADR); add(LD, 2, 0, 0, X_MRD);
    add(LD, 2, 0, 0, X_MRD); add(LD, 2, 0, 0, X_MRD);
    add(LD, 2, 0, 1, X_MRD); add(LD, 2, 0, 1, X_MWB);
    add(ST, 2, 0, 0, X_F0); add(ST, 2, 0, 1, X_F1);
    add(ST, 2, 0, 1, X_DEC); add(ST, 2, 0, 1, X_MADR);
    add(ST, 2, 0, 0, X_MWR0); add(ST, 2, 0, 1, X_MWR1);
    add(BR, 1, 3'b100, 1, X_F1); add(BR, 1, 3'b100, 1, X_DEC);
    add(BR, 1, 3'b100, 1, X_BRN);
    add(BR, 1, 3'b000, 1, X_F1); add(BR, 1, 3'b000, 1, X_DEC);
    add(BR, 1, 3'b000, 1, X_BRT);
    add(BR, 4, 3'b010, 1, X_F1); add(BR, 4, 3'b010, 1, X_DEC);
    add(BR, 4, 3'b010, 1, X_BRT);
    add(BR, 7, 3'b001, 1, X_F1); add(BR, 7, 3'b001, 1, X_DEC);
    add(BR, 7, 3'b001, 1, X_BRN);
    add(BR, 0, 3'b100, 1, X_F1); add(BR, 0, 3'b100, 1, X_DEC);
    add(BR, 0, 3'b100, 1, X_BRT);
    add(JL, 0, 0, 1, X_F1); add(JL, 0, 0, 1, X_DEC);
    add(JL, 0, 0, 1, X_JAL); add(JL, 0, 0, 1, X_AWB);
    add(JLR, 0, 0, 1, X_F1); add(JLR, 0, 0, 1, X_DEC);
    add(JLR, 0, 0, 1, X_JALR); add(JLR, 0, 0, 1, X_LINK);
    add(JLR, 0, 0, 1, X_AWB);
    add(LU, 0, 0, 1, X_F1); add(LU, 0, 0, 1, X_DEC);
    add(LU, 0, 0, 1, X_LUI); add(LU, 0, 0, 1, X_AWB);
    add(AUI, 0, 0, 1, X_F1); add(AUI, 0, 0, 1, X_DEC);
    add(AUI, 0, 0, 1, X_AUI); add(AUI, 0, 0, 1, X_AWB);
    add(SYS, 0, 0, 1, X_F1); add(SYS, 0, 0, 1, X_DEC);
    add(OPI, 0, 0, 1, X_TRAP); add(LD, 1, 3'b111, 0, X_TRAP);
    add(BR, 0, 3'b100, 1, X_TRAP);

    #1;
    check("rst_rdy0", X_F0);
    mem.memReady = 1'b1;
    #1;
    check("rst_rdy1", X_F1);
    mem.memReady = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("vec%0d", i), tbl[i].op, tbl[i].f3,
           tbl[i].flg, tbl[i].rdy, tbl[i].exp);

    checks++;
    if (retires != 13) begin
      failures++;
      $display("FAIL retire_count got=%0d want=13", retires);
    end

    // reset clears trap; reserved branch func3 traps without retiring
    do_reset();
    step("ib_f", BR, 3'b010, 3'b100, 1, X_F1);
    step("ib_d", BR, 3'b010, 3'b100, 1, X_DEC);
    step("ib_br", BR, 3'b010, 3'b100, 1, X_BRI);
    step("ib_trap", OPI, 3'b000, 3'b000, 1, X_TRAP);
    step("ib_trap2", ST, 3'b011, 3'b111, 0, X_TRAP);

    // reset during a MEMWRITE wait drops memWrite at once
    do_reset();
    step("sw_f", ST, 2, 0, 1, X_F1);
    step("sw_d", ST, 2, 0, 1, X_DEC);
    step("sw_a", ST, 2, 0, 1, X_MADR);
    step("sw_w", ST, 2, 0, 0, X_MWR0);
    #2;
    rst_n = 1'b0;
    #1;
    check("sw_rst", X_F0);
    @(posedge clk);
    #1;
    check("sw_rst_hold", X_F0);
    @(negedge clk);
    rst_n = 1'b1;
    step("ad_f", OPI, 0, 0, 1, X_F1);
    step("ad_d", OPI, 0, 0, 1, X_DEC);
    step("ad_e", OPI, 0, 0, 1, X_EXI);
    step("ad_w", OPI, 0, 0, 1, X_AWB);
    step("ad_f2", OPI, 0, 0, 0, X_F0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
